// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/return handshake bundle between a manycore requester and the
// local-memory responder.
interface bsg_manycore_mem_responder_if #(
   parameter int addr_width_p   = 10,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7
);
   logic                      req_v_i;
   logic                      req_yumi_o;
   logic [3:0]                req_op_i;
   logic [addr_width_p-1:0]   req_addr_i;
   logic [31:0]               req_data_i;
   logic [4:0]                req_reg_id_i;
   logic [6:0]                req_load_info_i;
   logic [x_cord_width_p-1:0] req_src_x_i;
   logic [y_cord_width_p-1:0] req_src_y_i;

   logic                      ret_v_o;
   logic                      ret_ready_i;
   logic [1:0]                ret_type_o;
   logic [31:0]               ret_data_o;
   logic [4:0]                ret_reg_id_o;
   logic [x_cord_width_p-1:0] ret_dst_x_o;
   logic [y_cord_width_p-1:0] ret_dst_y_o;

   modport master (
      output req_v_i, req_op_i, req_addr_i, req_data_i, req_reg_id_i,
             req_load_info_i, req_src_x_i, req_src_y_i, ret_ready_i,
      input  req_yumi_o, ret_v_o, ret_type_o, ret_data_o, ret_reg_id_o,
             ret_dst_x_o, ret_dst_y_o
   );

   modport slave (
      input  req_v_i, req_op_i, req_addr_i, req_data_i, req_reg_id_i,
             req_load_info_i, req_src_x_i, req_src_y_i, ret_ready_i,
      output req_yumi_o, ret_v_o, ret_type_o, ret_data_o, ret_reg_id_o,
             ret_dst_x_o, ret_dst_y_o
   );
endinterface

// File: rtl/bsg_manycore_mem_responder.sv
// Single-outstanding manycore memory endpoint: loads, stores, AMOs and
// credits against a local word memory with a 1-cycle synchronous read.
module bsg_manycore_mem_responder #(
   parameter int data_width_p   = 32,
   parameter int addr_width_p   = 10,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7
) (
   input logic clk_i,
   input logic reset_i,
   bsg_manycore_mem_responder_if.slave bus
);
   localparam logic [3:0] op_load_lp  = 4'd0,  op_store_lp = 4'd1,  op_sw_lp    = 4'd2;
   localparam logic [3:0] op_swap_lp  = 4'd4,  op_add_lp   = 4'd5,  op_xor_lp   = 4'd6;
   localparam logic [3:0] op_and_lp   = 4'd7,  op_or_lp    = 4'd8,  op_min_lp   = 4'd9;
   localparam logic [3:0] op_max_lp   = 4'd10, op_minu_lp  = 4'd11, op_maxu_lp  = 4'd12;
   localparam logic [1:0] ret_credit_lp = 2'd0, ret_int_wb_lp = 2'd1;
   localparam logic [1:0] ret_float_wb_lp = 2'd2, ret_ifetch_lp = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_e;

   function automatic logic is_amo(input logic [3:0] op);
      is_amo = (op >= 4'd4) && (op <= 4'd12);
   endfunction

   function automatic logic [data_width_p-1:0] amo_new(input logic [3:0] op,
      input logic [data_width_p-1:0] old_v, input logic [data_width_p-1:0] opnd);
      case (op)
         op_swap_lp: amo_new = opnd;
         op_add_lp:  amo_new = old_v + opnd;
         op_xor_lp:  amo_new = old_v ^ opnd;
         op_and_lp:  amo_new = old_v & opnd;
         op_or_lp:   amo_new = old_v | opnd;
         op_min_lp:  amo_new = ($signed(opnd) < $signed(old_v)) ? opnd : old_v;
         op_max_lp:  amo_new = ($signed(opnd) > $signed(old_v)) ? opnd : old_v;
         op_minu_lp: amo_new = (opnd < old_v) ? opnd : old_v;
         op_maxu_lp: amo_new = (opnd > old_v) ? opnd : old_v;
         default:    amo_new = old_v;
      endcase
   endfunction

   // load_info layout: {float_wb, icache_fetch, is_unsigned, is_byte, is_hex, part_sel[1:0]}
   function automatic logic [1:0] load_type(input logic [6:0] li);
      if (li[5])      load_type = ret_ifetch_lp;
      else if (li[6]) load_type = ret_float_wb_lp;
      else            load_type = ret_int_wb_lp;
   endfunction

   function automatic logic [data_width_p-1:0] load_data(input logic [6:0] li,
      input logic [data_width_p-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{li[1:0], 3'b000} +: 8];
      h = li[1] ? w[31:16] : w[15:0];
      if (li[5] || li[6]) load_data = w;
      else if (li[3])     load_data = li[4] ? {24'h000000, b} : {{24{b[7]}}, b};
      else if (li[2])     load_data = li[4] ? {16'h0000, h} : {{16{h[15]}}, h};
      else                load_data = w;
   endfunction

   logic [data_width_p-1:0]   mem_q [2**addr_width_p];
   state_e                    state_q, state_d;
   logic [3:0]                op_q, op_d;
   logic [addr_width_p-1:0]   addr_q, addr_d;
   logic [data_width_p-1:0]   data_q, data_d, rdata_q, rdata_d;
   logic [6:0]                load_info_q, load_info_d;
   logic                      ret_v_q, ret_v_d;
   logic [1:0]                ret_type_q, ret_type_d;
   logic [data_width_p-1:0]   ret_data_q, ret_data_d;
   logic [4:0]                ret_reg_id_q, ret_reg_id_d;
   logic [x_cord_width_p-1:0] ret_dst_x_q, ret_dst_x_d;
   logic [y_cord_width_p-1:0] ret_dst_y_q, ret_dst_y_d;
   logic                      yumi_s, mem_re_s, mem_we_s;
   logic [3:0]                mem_be_s;
   logic [addr_width_p-1:0]   mem_waddr_s;
   logic [data_width_p-1:0]   mem_wdata_s;

   // Next-state, request capture, memory port control and return formation.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      data_d       = data_q;
      load_info_d  = load_info_q;
      ret_v_d      = ret_v_q;
      ret_type_d   = ret_type_q;
      ret_data_d   = ret_data_q;
      ret_reg_id_d = ret_reg_id_q;
      ret_dst_x_d  = ret_dst_x_q;
      ret_dst_y_d  = ret_dst_y_q;
      yumi_s       = 1'b0;
      mem_re_s     = 1'b0;
      mem_we_s     = 1'b0;
      mem_be_s     = 4'b0000;
      mem_waddr_s  = bus.req_addr_i;
      mem_wdata_s  = bus.req_data_i;
      case (state_q)
         IDLE: begin
            if (bus.req_v_i && !reset_i) begin
               yumi_s       = 1'b1;
               op_d         = bus.req_op_i;
               addr_d       = bus.req_addr_i;
               data_d       = bus.req_data_i;
               load_info_d  = bus.req_load_info_i;
               ret_reg_id_d = bus.req_reg_id_i;
               ret_dst_x_d  = bus.req_src_x_i;
               ret_dst_y_d  = bus.req_src_y_i;
               ret_type_d   = ret_credit_lp;
               ret_data_d   = {data_width_p{1'b0}};
               if ((bus.req_op_i == op_load_lp) || is_amo(bus.req_op_i)) begin
                  mem_re_s = 1'b1;
                  state_d  = READ;
               end else begin
                  state_d = RESP;
                  ret_v_d = 1'b1;
                  if (bus.req_op_i == op_store_lp) begin
                     mem_we_s = 1'b1;
                     mem_be_s = bus.req_reg_id_i[3:0];
                  end else if (bus.req_op_i == op_sw_lp) begin
                     mem_we_s = 1'b1;
                     mem_be_s = 4'b1111;
                  end else begin
                     mem_we_s = 1'b0;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            state_d = RESP;
            ret_v_d = 1'b1;
            if (is_amo(op_q)) begin
               // A reset landing here drops the AMO without touching memory.
               mem_we_s    = !reset_i;
               mem_be_s    = 4'b1111;
               mem_waddr_s = addr_q;
               mem_wdata_s = amo_new(op_q, rdata_q, data_q);
               ret_type_d  = ret_int_wb_lp;
               ret_data_d  = rdata_q;
            end else begin
               ret_type_d  = load_type(load_info_q);
               ret_data_d  = load_data(load_info_q, rdata_q);
            end
         end
         RESP: begin
            if (bus.ret_ready_i) begin
               state_d = IDLE;
               ret_v_d = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            ret_v_d = 1'b0;
         end
      endcase
      if (mem_re_s) rdata_d = mem_q[bus.req_addr_i];
      else          rdata_d = rdata_q;
   end

   // Control and return registers; memory and read data are not reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         op_q         <= 4'd0;
         addr_q       <= {addr_width_p{1'b0}};
         data_q       <= {data_width_p{1'b0}};
         load_info_q  <= 7'd0;
         ret_v_q      <= 1'b0;
         ret_type_q   <= 2'd0;
         ret_data_q   <= {data_width_p{1'b0}};
         ret_reg_id_q <= 5'd0;
         ret_dst_x_q  <= {x_cord_width_p{1'b0}};
         ret_dst_y_q  <= {y_cord_width_p{1'b0}};
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         load_info_q  <= load_info_d;
         ret_v_q      <= ret_v_d;
         ret_type_q   <= ret_type_d;
         ret_data_q   <= ret_data_d;
         ret_reg_id_q <= ret_reg_id_d;
         ret_dst_x_q  <= ret_dst_x_d;
         ret_dst_y_q  <= ret_dst_y_d;
      end
      rdata_q <= rdata_d;
   end

   // Byte-enabled memory write port.
   always_ff @(posedge clk_i) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be_s[i]) mem_q[mem_waddr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
         end
      end
   end

   assign bus.req_yumi_o   = yumi_s;
   assign bus.ret_v_o      = ret_v_q;
   assign bus.ret_type_o   = ret_type_q;
   assign bus.ret_data_o   = ret_data_q;
   assign bus.ret_reg_id_o = ret_reg_id_q;
   assign bus.ret_dst_x_o  = ret_dst_x_q;
   assign bus.ret_dst_y_o  = ret_dst_y_q;
endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Randomised bench for bsg_manycore_mem_responder with a transaction-level
// memory model, a return scoreboard and literal pins on directed cases.
module tb_bsg_manycore_mem_responder;
   localparam int AW = 10;
   localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_SW = 4'd2, OP_CACHE = 4'd3;
   localparam logic [3:0] OP_SWAP = 4'd4, OP_ADD = 4'd5, OP_MIN = 4'd9, OP_MINU = 4'd11;
   localparam logic [1:0] RT_CREDIT = 2'd0, RT_INT = 2'd1, RT_IFETCH = 2'd3;

   typedef struct {
      logic [1:0]  t;
      logic [31:0] d;
      logic [4:0]  rid;
      logic [6:0]  dx;
      logic [6:0]  dy;
      int          lat;
      int          acc;
      bit          pin;
      logic [1:0]  pt;
      logic [31:0] pd;
   } exp_t;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   stall_until = 0;
   bit   rst_at_edge = 1'b0;
   bit   busy = 1'b0;
   exp_t q[$];
   logic [31:0] mem_m [0:1023];

   bsg_manycore_mem_responder_if #(.addr_width_p(AW), .x_cord_width_p(7), .y_cord_width_p(7)) bus();

   bsg_manycore_mem_responder #(.data_width_p(32), .addr_width_p(AW),
      .x_cord_width_p(7), .y_cord_width_p(7)) dut (
      .clk_i(clk), .reset_i(reset_i), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_at_edge <= reset_i;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Transaction-level reference: what a request returns and how memory changes.
   function automatic void model(input logic [3:0] op, input logic [AW-1:0] a,
      input logic [31:0] opnd, input logic [4:0] rid, input logic [6:0] li,
      output logic [1:0] t, output logic [31:0] d, output int lat);
      logic [31:0] old;
      int v, o;
      longint uv, uo;
      old = mem_m[a];
      v = old; o = opnd; uv = {32'd0, old}; uo = {32'd0, opnd};
      if (op == OP_LOAD) begin
         lat = 2;
         if (li[5])      begin t = RT_IFETCH; d = old; end
         else if (li[6]) begin t = 2'd2; d = old; end
         else begin
            t = RT_INT;
            if (li[3]) begin
               v = (old >> (8 * int'(li[1:0]))) & 255;
               if (!li[4] && v >= 128) v = v - 256;
               d = v;
            end else if (li[2]) begin
               v = (old >> (16 * int'(li[1]))) & 65535;
               if (!li[4] && v >= 32768) v = v - 65536;
               d = v;
            end else d = old;
         end
      end else if (op >= 4'd4 && op <= 4'd12) begin
         lat = 2; t = RT_INT; d = old;
         case (op)
            4'd4:  mem_m[a] = opnd;
            4'd5:  mem_m[a] = old + opnd;
            4'd6:  mem_m[a] = old ^ opnd;
            4'd7:  mem_m[a] = old & opnd;
            4'd8:  mem_m[a] = old | opnd;
            4'd9:  mem_m[a] = (o < v) ? opnd : old;
            4'd10: mem_m[a] = (o > v) ? opnd : old;
            4'd11: mem_m[a] = (uo < uv) ? opnd : old;
            default: mem_m[a] = (uo > uv) ? opnd : old;
         endcase
      end else begin
         lat = 1; t = RT_CREDIT; d = 32'd0;
         if (op == OP_SW) mem_m[a] = opnd;
         else if (op == OP_STORE) begin
            for (int i = 0; i < 4; i++) if (rid[i]) mem_m[a][8*i +: 8] = opnd[8*i +: 8];
         end
      end
   endfunction

   // Present one request, wait for acceptance, record what must come back.
   task automatic issue(input logic [3:0] op, input logic [AW-1:0] a, input logic [31:0] opnd,
      input logic [4:0] rid, input logic [6:0] li, input bit pin, input logic [1:0] pt,
      input logic [31:0] pd, input bit drop);
      bit got;
      exp_t e;
      logic [6:0] sx, sy;
      sx = 7'($urandom_range(0, 127));
      sy = 7'($urandom_range(0, 127));
      bus.req_v_i = 1'b1; bus.req_op_i = op; bus.req_addr_i = a; bus.req_data_i = opnd;
      bus.req_reg_id_i = rid; bus.req_load_info_i = li; bus.req_src_x_i = sx; bus.req_src_y_i = sy;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.req_yumi_o === 1'b1) got = 1'b1;
      end
      chk("accept_timeout", {63'd0, got}, 64'd1);
      if (got && !drop) begin
         model(op, a, opnd, rid, li, e.t, e.d, e.lat);
         e.rid = rid; e.dx = sx; e.dy = sy; e.acc = cyc; e.pin = pin; e.pt = pt; e.pd = pd;
         if (pin) chk("model_pin", {30'd0, e.t, e.d}, {30'd0, pt, pd});
         q.push_back(e);
      end
      @(posedge clk); #1;
      bus.req_v_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && (busy || q.size() != 0); i++) @(negedge clk);
      chk("idle_timeout", {63'd0, busy || q.size() != 0}, 64'd0);
      @(posedge clk); #1;
   endtask

   // Return-channel consumer: random back-pressure plus forced stall windows.
   initial begin
      bus.ret_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.ret_ready_i = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Per-cycle compare of handshake and return outputs against the scoreboard.
   initial begin
      bit seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         chk("req_yumi", {63'd0, bus.req_yumi_o}, {63'd0, bus.req_v_i && !busy && !reset_i});
         if (rst_at_edge)
            chk("reset_outputs", {10'd0, bus.ret_v_o, bus.ret_type_o, bus.ret_data_o,
                bus.ret_reg_id_o, bus.ret_dst_x_o, bus.ret_dst_y_o}, 64'd0);
         if (reset_i) begin
            q.delete(); busy = 1'b0; seen = 1'b0;
         end else begin
            if (bus.ret_v_o === 1'b1) begin
               if (q.size() == 0) chk("unexpected_ret", 64'd1, 64'd0);
               else begin
                  e = q[0];
                  chk("ret_fields", {10'd0, bus.ret_type_o, bus.ret_data_o, bus.ret_reg_id_o,
                      bus.ret_dst_x_o, bus.ret_dst_y_o}, {10'd0, e.t, e.d, e.rid, e.dx, e.dy});
                  if (!seen) begin
                     chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                     if (e.pin) chk("literal", {30'd0, bus.ret_type_o, bus.ret_data_o}, {30'd0, e.pt, e.pd});
                     seen = 1'b1;
                  end
                  if (bus.ret_ready_i) begin
                     void'(q.pop_front()); seen = 1'b0; busy = 1'b0;
                  end
               end
            end else if (q.size() != 0 && (cyc - q[0].acc) > q[0].lat) begin
               chk("ret_late", 64'(cyc - q[0].acc), 64'(q[0].lat));
               void'(q.pop_front()); busy = 1'b0;
            end
            if (bus.req_yumi_o === 1'b1) busy = 1'b1;
         end
      end
   end

   // Directed scenarios with literal expectations, then randomised traffic.
   initial begin
      logic [31:0] dv;
      bus.req_v_i = 1'b0; bus.req_op_i = 4'd0; bus.req_addr_i = '0; bus.req_data_i = 32'd0;
      bus.req_reg_id_i = 5'd0; bus.req_load_info_i = 7'd0; bus.req_src_x_i = 7'd0; bus.req_src_y_i = 7'd0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;

      issue(OP_SW,    10'd5, 32'hDEADBEEF, 5'd3,  7'b0000000, 1, RT_CREDIT, 32'h00000000, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd9,  7'b0000000, 1, RT_INT,    32'hDEADBEEF, 0);
      issue(OP_STORE, 10'd5, 32'h00110000, 5'd4,  7'b0000000, 1, RT_CREDIT, 32'h00000000, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd1,  7'b0001010, 1, RT_INT,    32'h00000011, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd2,  7'b0001011, 1, RT_INT,    32'hFFFFFFDE, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd3,  7'b0010110, 1, RT_INT,    32'h0000DE11, 0);
      issue(OP_SW,    10'd7, 32'hFFFFFFFF, 5'd0,  7'b0000000, 0, RT_CREDIT, 32'h0, 0);
      issue(OP_MIN,   10'd7, 32'd1,        5'd11, 7'b0000000, 1, RT_INT,    32'hFFFFFFFF, 0);
      issue(OP_LOAD,  10'd7, 32'd0,        5'd12, 7'b0000000, 1, RT_INT,    32'hFFFFFFFF, 0);
      issue(OP_MINU,  10'd7, 32'd1,        5'd13, 7'b0000000, 1, RT_INT,    32'hFFFFFFFF, 0);
      issue(OP_LOAD,  10'd7, 32'd0,        5'd14, 7'b0000000, 1, RT_INT,    32'h00000001, 0);
      issue(OP_ADD,   10'd7, 32'hFFFFFFFF, 5'd15, 7'b0000000, 1, RT_INT,    32'h00000001, 0);
      issue(OP_LOAD,  10'd7, 32'd0,        5'd16, 7'b0000000, 1, RT_INT,    32'h00000000, 0);

      // Held-off return while a second request waits at the door.
      wait_idle();
      stall_until = cyc + 9;
      issue(OP_LOAD,  10'd5, 32'd0,        5'd17, 7'b1100000, 1, RT_IFETCH, 32'hDE11BEEF, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd18, 7'b0000000, 1, RT_INT,    32'hDE11BEEF, 0);

      // AMO interrupted by reset in its read cycle must leave memory alone.
      wait_idle();
      issue(OP_SWAP,  10'd7, 32'h12345678, 5'd19, 7'b0000000, 0, RT_INT,    32'h0, 1);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      issue(OP_LOAD,  10'd7, 32'd0,        5'd20, 7'b0000000, 1, RT_INT,    32'h00000000, 0);
      issue(OP_CACHE, 10'd5, 32'hCAFEF00D, 5'd21, 7'b0000000, 1, RT_CREDIT, 32'h00000000, 0);
      issue(OP_STORE, 10'd5, 32'h55555555, 5'd16, 7'b0000000, 1, RT_CREDIT, 32'h00000000, 0);
      issue(OP_LOAD,  10'd5, 32'd0,        5'd22, 7'b0000000, 1, RT_INT,    32'hDE11BEEF, 0);
      issue(4'd14,    10'd5, 32'h0BADF00D, 5'd23, 7'b0000000, 1, RT_CREDIT, 32'h00000000, 0);

      for (int i = 0; i < 16; i++)
         issue(OP_SW, AW'(i), $urandom, 5'($urandom_range(0, 31)), 7'd0, 0, RT_CREDIT, 32'h0, 0);
      for (int i = 0; i < 250; i++) begin
         case ($urandom_range(0, 5))
            0: dv = 32'h00000000;
            1: dv = 32'hFFFFFFFF;
            2: dv = 32'h80000000;
            3: dv = 32'h7FFFFFFF;
            default: dv = $urandom;
         endcase
         issue(4'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), dv,
               5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)), 0, RT_CREDIT, 32'h0, 0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      wait_idle();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bsg_manycore_mem_responder.md
BSG_MANYCORE_MEM_RESPONDER -- requirements
Module: bsg_manycore_mem_responder

Interface
REQ-001 SHALL have parameter data_width_p, default 32, data word width (fixed at 32).
REQ-002 SHALL have parameter addr_width_p, default 10, word-address width; local memory depth is 2**addr_width_p words.
REQ-003 SHALL have parameters x_cord_width_p and y_cord_width_p, default 7 each, source/destination coordinate widths.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i in 1, rising-edge clock; reset_i in 1, synchronous active-high reset.
REQ-005 SHALL have req_v_i in 1, request valid; req_yumi_o out 1, request consumed this cycle.
REQ-006 SHALL have req_op_i in 4, bsg_manycore_packet_op_e; req_addr_i in addr_width_p, word address; req_data_i in 32, store/AMO operand.
REQ-007 SHALL have req_reg_id_i in 5: store byte mask (bits [3:0]) for e_remote_store, tracking id otherwise; req_load_info_i in 7, bsg_manycore_load_info_s.
REQ-008 SHALL have req_src_x_i in x_cord_width_p and req_src_y_i in y_cord_width_p, requester coordinates.
REQ-009 SHALL have ret_v_o out 1; ret_ready_i in 1; ret_type_o out 2, bsg_manycore_return_packet_type_e; ret_data_o out 32; ret_reg_id_o out 5; ret_dst_x_o out x_cord_width_p; ret_dst_y_o out y_cord_width_p.

Function
REQ-010 SHALL implement states IDLE, READ, RESP, with one request in flight at most.
REQ-011 In IDLE, req_yumi_o SHALL equal req_v_i; on accept, op, addr, data, reg_id, load_info and src coordinates SHALL be latched.
REQ-012 In READ and RESP, req_yumi_o SHALL be 0.
REQ-013 Memory SHALL be 32-bit words with byte-write enables and a 1-cycle synchronous read.
REQ-014 On e_remote_load or any AMO accept, the memory read SHALL issue in the accept cycle and the state SHALL go to READ.
REQ-015 On e_remote_store accept, bytes enabled by reg_id[3:0] SHALL be written in the accept cycle; mask 0 writes nothing; the state SHALL go to RESP.
REQ-016 On e_remote_sw accept, the full word SHALL be written in the accept cycle; the state SHALL go to RESP.
REQ-017 e_cache_op and op codes 13-15 SHALL have no memory effect; the state SHALL go to RESP.
REQ-018 In READ with a load, ret_data SHALL be formed per REQ-023 and the state SHALL go to RESP.
REQ-019 In READ with an AMO, the new value SHALL be written to the same address; ret_data SHALL be the old value; the state SHALL go to RESP.
REQ-020 AMO new value SHALL be as follows: swap = operand; add = old+operand mod 2**32; xor/and/or bitwise; min/max signed compare; minu/maxu unsigned compare; on ties, keep old.
REQ-021 Load ret_type SHALL be e_return_ifetch if icache_fetch=1, else e_return_float_wb if float_wb=1, else e_return_int_wb; icache_fetch takes priority when both are set.
REQ-022 Stores, sw, cache_op and undefined ops SHALL return e_return_credit with ret_data 0; AMOs SHALL return e_return_int_wb.
REQ-023 For int_wb loads:
- is_byte_op: SHALL select byte part_sel, zero-extend if is_unsigned_op, else sign-extend.
- is_hex_op: SHALL select half part_sel[1], same extension rule.
- neither: full word.
- ifetch/float_wb: SHALL return the full word and ignore the size bits.
REQ-024 ret_reg_id_o SHALL equal the latched reg_id; ret_dst_x_o/ret_dst_y_o SHALL equal the latched src coordinates.
REQ-025 In RESP, ret_v_o SHALL be 1 and all ret_* outputs SHALL be held stable until ret_ready_i=1; on that cycle, the state SHALL go to IDLE.
REQ-026 Latency from accept to ret_v_o SHALL be: 1 cycle for store/sw/cache_op; 2 cycles for load/AMO.
REQ-027 A new request SHALL NOT be accepted in the cycle ret handshakes complete; the earliest next accept is the following cycle.

Reset
REQ-028 While reset_i=1: state SHALL go to IDLE; ret_v_o=0, req_yumi_o=0; ret_type_o, ret_data_o, ret_reg_id_o, ret_dst_x_o, ret_dst_y_o SHALL be 0.
REQ-029 Reset asserted in READ SHALL suppress the AMO write-back; the in-flight request SHALL be dropped with no return.
REQ-030 Reset SHALL NOT clear memory contents; words written before reset SHALL be readable after reset.

Verification
REQ-031 sw addr 5, data 0xDEADBEEF, reg_id 3 -> credit, reg_id 3; then load addr 5, int_wb, word -> int_wb, data 0xDEADBEEF, 2 cycles after accept.
REQ-032 store addr 5, data 0x00110000, mask 0b0100; then load byte part_sel 2 signed -> 0x00000011; part_sel 3 signed -> 0xFFFFFFDE; hex part_sel[1]=1 unsigned -> 0x0000DE11.
REQ-033 mem[7]=0xFFFFFFFF; amomin 1 -> ret 0xFFFFFFFF, mem 0xFFFFFFFF; amominu 1 -> ret 0xFFFFFFFF, mem 1; amoadd 0xFFFFFFFF -> ret 1, mem 0.
REQ-034 Load with icache_fetch=1 and float_wb=1 -> e_return_ifetch, full word; ret_ready_i held 0 for 5 cycles -> outputs stable and req_yumi_o=0 throughout.
REQ-035 amoswap accepted, reset_i pulsed in READ -> no return, memory unchanged; cache_op e_afl -> credit, memory unchanged.
